// File: rtl/store_merge_unit.sv
// store_merge_unit
//   Store path into a word-wide data memory that has no byte enables.
//   A full-word store is written straight through. A byte or halfword store
//   is a read-modify-write: the containing word is read, the addressed lane
//   is merged in, and the word is written back.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  store request handshake (ready only in IDLE)
//   req_addr               byte address
//   req_data               store data (low byte/halfword used for SB/SH)
//   req_size               00 SW, 01 SH, 10 SB, 11 illegal
//   mem_addr               word-aligned memory address
//   mem_rd_en / mem_rdata  read strobe; data returns one cycle later
//   mem_wr_en / mem_wdata  write strobe and data
//   done                   one-cycle pulse when the store has been written
//   misaligned             one-cycle pulse when a request was rejected
module store_merge_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic              misaligned
);

   localparam int          NUM_LANES = 4;
   localparam logic [1:0]  SZ_W      = 2'b00;
   localparam logic [1:0]  SZ_H      = 2'b01;
   localparam logic [1:0]  SZ_B      = 2'b10;

   typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

   state_t                 state_q, state_d;
   logic [1:0]             off_q, off_d;
   logic [1:0]             size_q, size_d;
   logic [31:0]            data_q, data_d;
   logic [ADDR_W-1:0]      addr_d;
   logic [31:0]            wdata_d;
   logic                   rd_d, wr_d, done_d, mis_d;
   logic                   bad_req;

   logic [NUM_LANES-1:0]        lane_en;
   logic [NUM_LANES-1:0][7:0]   merged;

   assign req_ready = (state_q == IDLE);

   // Rejected without touching memory: illegal size, odd halfword,
   // or a word that is not 4-byte aligned. Bytes are never misaligned.
   assign bad_req = (req_size == 2'b11) ||
                    ((req_size == SZ_H) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

   // Lanes overwritten by the latched sub-word store.
   always_comb begin
      lane_en = '0;
      if (size_q == SZ_B)
         lane_en = 4'b0001 << off_q;
      else if (size_q == SZ_H)
         lane_en = off_q[1] ? 4'b1100 : 4'b0011;
   end

   // Per-byte merge of the read word. A byte store replicates data[7:0]
   // to every lane candidate; a halfword store feeds data[15:8] to the odd
   // lanes and data[7:0] to the even lanes, and lane_en picks the target.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam int HB = i % 2;
      logic [7:0] src;
      always_comb begin
         src = (size_q == SZ_B) ? data_q[7:0] : data_q[8*HB +: 8];
         merged[i] = lane_en[i] ? src : mem_rdata[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      size_d  = size_q;
      data_d  = data_q;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (bad_req) begin
                  mis_d = 1'b1;
               end else begin
                  addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                  off_d  = req_addr[1:0];
                  size_d = req_size;
                  data_d = req_data;
                  if (req_size == SZ_W) begin
                     // Full word: no read needed, write on the next cycle.
                     state_d = WRITE;
                     wdata_d = req_data;
                     wr_d    = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d = READ;
                     rd_d    = 1'b1;
                  end
               end
            end
         end
         // mem_rd_en is high during READ; read data arrives during WAIT.
         READ:  state_d = WAIT;
         WAIT: begin
            state_d = WRITE;
            wdata_d = merged;
            wr_d    = 1'b1;
            done_d  = 1'b1;
         end
         WRITE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         off_q      <= '0;
         size_q     <= '0;
         data_q     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rd_en  <= 1'b0;
         mem_wr_en  <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         size_q     <= size_d;
         data_q     <= data_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         mem_rd_en  <= rd_d;
         mem_wr_en  <= wr_d;
         done       <= done_d;
         misaligned <= mis_d;
      end
   end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboarded bench for store_merge_unit: stimulus pushes expected reads
// and write/misaligned events; a negedge monitor pops and compares them.
module tb_store_merge_unit;

   localparam int AW = 32;
   localparam int K_SW = 0, K_RMW = 1, K_MIS = 2, K_ABORT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_data = '0;
   logic [1:0]    req_size = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [31:0]   mem_rdata = 32'hDEADDEAD;
   logic          mem_wr_en;
   logic [31:0]   mem_wdata;
   logic          done;
   logic          misaligned;

   store_merge_unit #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .done(done),
      .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: returns mem_word one cycle after a read strobe,
   // garbage otherwise so a mistimed capture shows up.
   logic [31:0] mem_word = '0;
   always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word : 32'hDEADDEAD;

   typedef struct {bit mis; logic [31:0] addr; logic [31:0] data; int cyc;} ev_t;
   typedef struct {logic [31:0] addr; int cyc;} rd_t;
   ev_t evq[$];
   rd_t rdq[$];

   int n_chk = 0, n_pass = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endfunction

   // Monitor
   ev_t me;
   rd_t mr;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 1, 0);
         if (done && misaligned) chk("done_mis_overlap", 1, 0);
         if (mem_rd_en) begin
            if (rdq.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               mr = rdq.pop_front();
               chk("rd_addr", mem_addr, mr.addr);
               chk("rd_cycle", cyc, mr.cyc);
            end
         end
         if (mem_wr_en || done) begin
            if (evq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               me = evq.pop_front();
               chk("write_expected", {31'd0, me.mis}, 0);
               chk("wr_en", {31'd0, mem_wr_en}, 1);
               chk("done", {31'd0, done}, 1);
               chk("wr_addr", mem_addr, me.addr);
               chk("wr_data", mem_wdata, me.data);
               chk("wr_cycle", cyc, me.cyc);
            end
         end
         if (misaligned) begin
            if (evq.size() == 0) chk("unexpected_misaligned", 1, 0);
            else begin
               me = evq.pop_front();
               chk("mis_expected", {31'd0, me.mis}, 1);
               chk("mis_cycle", cyc, me.cyc);
               chk("mis_ready", {31'd0, req_ready}, 1);
            end
         end
      end
   end

   // Issue one request; waits for ready, pushes the hand-computed outcome.
   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input int kind, input logic [31:0] memw, input logic [31:0] expw,
                       input bit hold, output int acc);
      acc = -1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_addr  = a;
         req_data  = d;
         req_size  = s;
         if (req_ready) begin
            acc = cyc;
            mem_word = memw;
            case (kind)
               K_SW:    evq.push_back('{0, a & ~32'd3, expw, acc + 1});
               K_RMW: begin
                  rdq.push_back('{a & ~32'd3, acc + 1});
                  evq.push_back('{0, a & ~32'd3, expw, acc + 3});
               end
               K_MIS:   evq.push_back('{1, 32'd0, 32'd0, acc + 1});
               default: rdq.push_back('{a & ~32'd3, acc + 1});
            endcase
            @(posedge clk);
            #1;
            if (!hold) req_valid = 1'b0;
            return;
         end
      end
      chk("accept_timeout", 1, 0);
      req_valid = 1'b0;
   endtask

   task automatic chk_idle(string nm);
      chk({nm, "_ready"}, {31'd0, req_ready}, 1);
      chk({nm, "_rd_en"}, {31'd0, mem_rd_en}, 0);
      chk({nm, "_wr_en"}, {31'd0, mem_wr_en}, 0);
      chk({nm, "_done"},  {31'd0, done}, 0);
      chk({nm, "_mis"},   {31'd0, misaligned}, 0);
      chk({nm, "_addr"},  mem_addr, 0);
      chk({nm, "_wdata"}, mem_wdata, 0);
   endtask

   int a1, a2, a3;

   initial begin
      repeat (2) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);

      send(32'h10, 32'hDEADBEEF, 2'b00, K_SW,  32'h0,        32'hDEADBEEF, 0, a1);
      send(32'h22, 32'h000000AB, 2'b10, K_RMW, 32'h11223344, 32'h11AB3344, 0, a1);
      send(32'h42, 32'hFFFFCAFE, 2'b01, K_RMW, 32'h55667788, 32'hCAFE7788, 0, a1);
      send(32'h40, 32'hFFFFCAFE, 2'b01, K_RMW, 32'h55667788, 32'h5566CAFE, 0, a1);
      send(32'h21, 32'h00000055, 2'b10, K_RMW, 32'h11223344, 32'h11225544, 0, a1);
      send(32'h23, 32'h00000099, 2'b10, K_RMW, 32'h11223344, 32'h99223344, 0, a1);
      send(32'h20, 32'h00000001, 2'b10, K_RMW, 32'h11223344, 32'h11223301, 0, a1);

      // Misaligned requests back to back: each accepted one cycle apart.
      send(32'h03, 32'h1, 2'b01, K_MIS, 32'h0, 32'h0, 1, a1);
      send(32'h06, 32'h2, 2'b00, K_MIS, 32'h0, 32'h0, 1, a2);
      send(32'h08, 32'h3, 2'b11, K_MIS, 32'h0, 32'h0, 0, a3);
      chk("mis_b2b_1", a2 - a1, 1);
      chk("mis_b2b_2", a3 - a2, 1);

      // SB then SW with req_valid held: second accepted four cycles later.
      send(32'h104, 32'h0000007F, 2'b10, K_RMW, 32'hA0B0C0D0, 32'hA0B0C07F, 1, a1);
      send(32'h108, 32'h12345678, 2'b00, K_SW,  32'hA0B0C0D0, 32'h12345678, 0, a2);
      chk("b2b_accept_gap", a2 - a1, 4);

      // Reset while the SB sits in WAIT: no write may follow.
      send(32'h22, 32'h000000AB, 2'b10, K_ABORT, 32'h11223344, 32'h0, 0, a1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle("abort");
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_write", {31'd0, mem_wr_en}, 0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      send(32'h30, 32'hCAFEBABE, 2'b00, K_SW, 32'h0, 32'hCAFEBABE, 0, a1);

      for (int t = 0; t < 20 && (evq.size() != 0 || rdq.size() != 0); t++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain_events", evq.size(), 0);
      chk("drain_reads", rdq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
